flash_read_seq: RTL and testbench
=================================

// Module: flash_read_seq
//
// PURPOSE
// Command sequencer for the register-mapped SPI flash controller (SB_SPI window, 4-bit register address).
// On one start pulse it performs a standard READ (0x03) of i_len bytes at a 24-bit flash address.
// It drives the controller's en/wr/addr/data/ack register port and streams the bytes out on a valid/ready port.
// It replaces hand-written poll loops in bring-up and boot FSMs; it is the only master of that port while o_busy=1.
//
// PARAMETERS
// LEN_W       16     width of i_len; max transfer 2**LEN_W-1 bytes
// ACK_TMO     255    cycles to wait for i_bus_ack before abort (8-bit counter)
// REG_SR      4'hC   status register address
// REG_TXDR    4'hD   transmit data register address
// REG_RXDR    4'hE   receive data register address
// REG_CSR     4'hF   chip-select register address
// SR_TRDY     4      SR bit index: transmit ready
// SR_RRDY     3      SR bit index: receive ready
// CS_ON       8'hFE  CSR value that asserts flash CS
// CS_OFF      8'hFF  CSR value that releases flash CS
//
// PORTS
// i_clk        in   1      system clock
// i_rst_n      in   1      asynchronous active-low reset
// i_start      in   1      start pulse; sampled only in IDLE
// i_addr       in   24     flash byte address; latched on accepted start
// i_len        in   LEN_W  byte count; latched on accepted start
// o_busy       out  1      high from the cycle after start until DONE
// o_done       out  1      1-cycle pulse: transfer complete
// o_err        out  1      1-cycle pulse, together with o_done: ack timeout abort
// o_data       out  8      stream byte
// o_valid      out  1      o_data valid
// i_ready      in   1      consumer accepts when o_valid&i_ready
// o_bus_en     out  1      register access request
// o_bus_wr     out  1      1=write, 0=read
// o_bus_addr   out  4      register address
// o_bus_data   out  8      write data
// i_bus_ack    in   1      access complete
// i_bus_data   in   8      read data, valid while i_bus_ack=1
//
// BEHAVIOUR
// - Reset (async): all outputs 0, state IDLE, counters 0; reset mid-transfer drops o_bus_en at once. CS is not restored; the caller also resets the flash controller.
// - Bus access (ACC sub-state, return state held in link reg):
//   o_bus_en/wr/addr/data are set together and held stable until the cycle i_bus_ack=1.
//   Read data is captured in that cycle. o_bus_en drops the next cycle, giving at least one idle cycle between accesses.
// - Ack timeout: a counter resets each access. If it reaches ACK_TMO with no ack: o_bus_en=0, then a best-effort-free abort: no CS_OFF write, o_done=o_err=1 for one cycle, then IDLE.
// - FSM:
//   IDLE -> (i_start) latch addr/len.
//     len==0: DONE next cycle, with no bus traffic.
//     Otherwise: CS_ASSERT (write CSR=CS_ON).
//   XFER loop, over bytes 0x03, A[23:16], A[15:8], A[7:0], then i_len dummy 0x00 bytes:
//     TX_POLL: read SR until bit SR_TRDY=1.
//     TX_WR: write TXDR.
//     RX_POLL: read SR until bit SR_RRDY=1.
//     RX_RD: read RXDR. Bytes 0..3 are discarded; data bytes go to OUT.
//   OUT: o_valid=1 with o_data held. Leave on o_valid&i_ready. No further SPI byte is issued while OUT waits (backpressure stalls the bus).
//   After the last data byte is accepted: CS_RELEASE (write CSR=CS_OFF) -> DONE (o_done=1, o_busy=0 the same cycle) -> IDLE.
// - Latency: first possible start is accepted in IDLE; o_busy rises the next cycle. One bus access is at minimum 2 cycles.
// - The byte counter counts down from i_len. The 24-bit address is sent as latched; there is no wrap logic, because the flash wraps internally.
// - i_start while busy: ignored. Start in the same cycle as DONE: ignored; accepted from IDLE only.
//
// TESTING
// 1 addr=0x100000, len=3, model returns A5,5A,C3, ready=1: bus writes CSR FE; TXDR 03,10,00,00,00,00,00; CSR FF. Stream = A5,5A,C3; one o_done, o_err=0.
// 2 len=0: o_done pulse 2 cycles after start; zero o_bus_en cycles.
// 3 SR returns TRDY=0 for 10 reads, then 1: exactly 11 SR reads precede that TXDR write; data still correct.
// 4 i_ready low for 50 cycles on byte 2 of 4: o_data stable and o_valid high throughout; no TXDR write during the stall.
// 5 Model withholds ack at 2nd access: o_bus_en drops after 255 cycles; o_done=o_err=1 for 1 cycle; next start works.
// 6 i_rst_n low mid-XFER: all outputs 0 asynchronously; after release a fresh len=1 read completes correctly.

Source files
------------

// File: rtl/flash_read_seq.sv
// flash_read_seq: issues a standard SPI flash READ (0x03 + 24-bit address +
// i_len dummy bytes) through the SB_SPI register window and streams the
// returned data bytes out on a valid/ready port.
//
// Bus port: o_bus_en/wr/addr/data are driven together and held until the
// cycle i_bus_ack=1; o_bus_en drops the cycle after, so consecutive accesses
// are separated by at least one idle cycle.
// Stream port: o_data is held and o_valid stays high until the cycle with
// o_valid & i_ready; that cycle completes the transfer of the byte.
module flash_read_seq #(
  parameter int          LEN_W    = 16,
  parameter int          ACK_TMO  = 255,
  parameter logic [3:0]  REG_SR   = 4'hC,
  parameter logic [3:0]  REG_TXDR = 4'hD,
  parameter logic [3:0]  REG_RXDR = 4'hE,
  parameter logic [3:0]  REG_CSR  = 4'hF,
  parameter int          SR_TRDY  = 4,
  parameter int          SR_RRDY  = 3,
  parameter logic [7:0]  CS_ON    = 8'hFE,
  parameter logic [7:0]  CS_OFF   = 8'hFF
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic [23:0]      i_addr,
  input  logic [LEN_W-1:0] i_len,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_err,
  output logic [7:0]       o_data,
  output logic             o_valid,
  input  logic             i_ready,
  output logic             o_bus_en,
  output logic             o_bus_wr,
  output logic [3:0]       o_bus_addr,
  output logic [7:0]       o_bus_data,
  input  logic             i_bus_ack,
  input  logic [7:0]       i_bus_data,
  output logic [3:0]       o_dbg_state
);

  typedef enum logic [3:0] {
    S_IDLE, S_CS_ON, S_TX_POLL, S_TX_WR, S_RX_POLL,
    S_RX_RD, S_ACC, S_OUT, S_CS_OFF, S_DONE
  } state_e;

  localparam logic [7:0] TMO_LAST = 8'(ACK_TMO - 1);

  state_e           state_q, link_q;
  logic [23:0]      addr_q;
  logic [LEN_W-1:0] len_q;
  logic [2:0]       hdr_q;   // header bytes already received (0..4)
  logic [7:0]       tmo_q;
  logic             busy_q, done_q, err_q, valid_q;
  logic [7:0]       data_q;
  logic             en_q, wr_q;
  logic [3:0]       baddr_q;
  logic [7:0]       bdata_q;

  logic [7:0]       tx_byte;
  logic             acc_wr;
  logic [3:0]       acc_addr;
  logic [7:0]       acc_data;

  // Byte to shift out next: command, address MSB first, then dummies.
  always_comb begin
    tx_byte = 8'h00;
    case (hdr_q)
      3'd0:    tx_byte = 8'h03;
      3'd1:    tx_byte = addr_q[23:16];
      3'd2:    tx_byte = addr_q[15:8];
      3'd3:    tx_byte = addr_q[7:0];
      default: tx_byte = 8'h00;
    endcase
  end

  // Register access launched by the current state (polls default to SR read).
  always_comb begin
    acc_wr   = 1'b0;
    acc_addr = REG_SR;
    acc_data = 8'h00;
    case (state_q)
      S_CS_ON:  begin acc_wr = 1'b1; acc_addr = REG_CSR;  acc_data = CS_ON;   end
      S_TX_WR:  begin acc_wr = 1'b1; acc_addr = REG_TXDR; acc_data = tx_byte; end
      S_RX_RD:  begin acc_addr = REG_RXDR; end
      S_CS_OFF: begin acc_wr = 1'b1; acc_addr = REG_CSR;  acc_data = CS_OFF;  end
      default:  begin end
    endcase
  end

  // Sequencer FSM with registered bus and stream outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      link_q  <= S_IDLE;
      addr_q  <= '0;
      len_q   <= '0;
      hdr_q   <= '0;
      tmo_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      valid_q <= 1'b0;
      data_q  <= '0;
      en_q    <= 1'b0;
      wr_q    <= 1'b0;
      baddr_q <= '0;
      bdata_q <= '0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (i_start) begin
            addr_q  <= i_addr;
            len_q   <= i_len;
            hdr_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= S_CS_ON;
          end
        end
        S_CS_ON, S_TX_POLL, S_TX_WR, S_RX_POLL, S_RX_RD, S_CS_OFF: begin
          if (state_q == S_CS_ON && len_q == '0) begin
            // Empty transfer: finish without touching the bus.
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else begin
            en_q    <= 1'b1;
            wr_q    <= acc_wr;
            baddr_q <= acc_addr;
            bdata_q <= acc_data;
            link_q  <= state_q;
            tmo_q   <= '0;
            state_q <= S_ACC;
          end
        end
        S_ACC: begin
          if (i_bus_ack) begin
            en_q <= 1'b0;
            case (link_q)
              S_CS_ON:   state_q <= S_TX_POLL;
              S_TX_POLL: state_q <= i_bus_data[SR_TRDY] ? S_TX_WR : S_TX_POLL;
              S_TX_WR:   state_q <= S_RX_POLL;
              S_RX_POLL: state_q <= i_bus_data[SR_RRDY] ? S_RX_RD : S_RX_POLL;
              S_RX_RD: begin
                if (hdr_q != 3'd4) begin
                  hdr_q   <= hdr_q + 3'd1;
                  state_q <= S_TX_POLL;
                end else begin
                  data_q  <= i_bus_data;
                  valid_q <= 1'b1;
                  state_q <= S_OUT;
                end
              end
              S_CS_OFF: begin
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
                state_q <= S_DONE;
              end
              default: state_q <= S_IDLE;
            endcase
          end else if (tmo_q == TMO_LAST) begin
            // Controller stopped answering: abandon, leave CS as it is.
            en_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            err_q   <= 1'b1;
            state_q <= S_DONE;
          end else begin
            tmo_q <= tmo_q + 8'd1;
          end
        end
        S_OUT: begin
          if (i_ready) begin
            valid_q <= 1'b0;
            len_q   <= len_q - LEN_W'(1);
            state_q <= (len_q == LEN_W'(1)) ? S_CS_OFF : S_TX_POLL;
          end
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign o_busy      = busy_q;
  assign o_done      = done_q;
  assign o_err       = err_q;
  assign o_data      = data_q;
  assign o_valid     = valid_q;
  assign o_bus_en    = en_q;
  assign o_bus_wr    = wr_q;
  assign o_bus_addr  = baddr_q;
  assign o_bus_data  = bdata_q;
  assign o_dbg_state = state_q;

endmodule

// File: tb/tb_flash_read_seq.sv
// tb_flash_read_seq: drives flash_read_seq against a behavioural SPI flash
// controller model and a stream consumer; checks bus traffic and data.
module tb_flash_read_seq;
  localparam int LEN_W = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc++;

  // ---------------- DUT ----------------
  logic             start = 1'b0;
  logic [23:0]      addr = '0;
  logic [LEN_W-1:0] len = '0;
  logic             ready = 1'b0;
  logic             bus_ack = 1'b0;
  logic [7:0]       bus_rdata = '0;
  logic             busy, done, err, valid, bus_en, bus_wr;
  logic [7:0]       data, bus_wdata;
  logic [3:0]       bus_addr, dbg_state;

  flash_read_seq dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_addr(addr), .i_len(len),
    .o_busy(busy), .o_done(done), .o_err(err), .o_data(data), .o_valid(valid),
    .i_ready(ready), .o_bus_en(bus_en), .o_bus_wr(bus_wr), .o_bus_addr(bus_addr),
    .o_bus_data(bus_wdata), .i_bus_ack(bus_ack), .i_bus_data(bus_rdata),
    .o_dbg_state(dbg_state)
  );

  // ---------------- scoreboard ----------------
  int errors = 0;
  int checks = 0;
  logic [7:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Flash contents as a plain function of the byte address.
  function automatic logic [7:0] mem_byte(input logic [23:0] a);
    logic [23:0] t;
    t = (a * 24'd37) ^ (a >> 8) ^ (a >> 16);
    return t[7:0] ^ 8'h5C;
  endfunction

  // ---------------- controller + flash model ----------------
  logic [7:0] txdr_q[$];
  logic [7:0] csr_q[$];
  logic [7:0] force_q[$];
  bit   force_on = 0, rand_sr = 0;
  int   rx_cnt = 0, sr_reads = 0, acc_idx = 0, withhold_at = 0;
  int   ack_dly_max = 0, wait_cnt = 0, cur_dly = 0, trdy_block = 0, sr_at_tx0 = -1;

  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      bus_ack = 1'b0;
      wait_cnt = 0;
    end else if (bus_ack) begin
      bus_ack = 1'b0;
      wait_cnt = 0;
    end else if (bus_en) begin
      if (wait_cnt == 0) begin
        acc_idx++;
        cur_dly = $urandom_range(ack_dly_max, 0);
      end
      wait_cnt++;
      if (acc_idx != withhold_at && wait_cnt > cur_dly) begin
        bus_ack = 1'b1;
        bus_rdata = 8'($urandom);
        if (bus_wr) begin
          if (bus_addr == 4'hD) begin
            txdr_q.push_back(bus_wdata);
            if (txdr_q.size() == 1) sr_at_tx0 = sr_reads;
          end else if (bus_addr == 4'hF) begin
            csr_q.push_back(bus_wdata);
          end
        end else if (bus_addr == 4'hC) begin
          sr_reads++;
          if (trdy_block > 0) begin
            trdy_block--;
            bus_rdata = 8'h00;
          end else if (rand_sr && $urandom_range(3, 0) == 0) begin
            bus_rdata = 8'($urandom) & 8'hE7;
          end else begin
            bus_rdata = 8'($urandom) | 8'h18;
          end
        end else if (bus_addr == 4'hE) begin
          if (rx_cnt >= 4 && txdr_q.size() >= 4) begin
            if (force_on) bus_rdata = force_q[rx_cnt - 4];
            else bus_rdata = mem_byte({txdr_q[1], txdr_q[2], txdr_q[3]} + 24'(rx_cnt - 4));
          end
          rx_cnt++;
        end
      end
    end else begin
      wait_cnt = 0;
    end
  end

  // ---------------- stream consumer ----------------
  bit   rand_ready = 0;
  int   rcv_cnt = 0, stall_at = -1, stall_left = 0;
  bit   stall_seen = 0;
  logic [7:0] stall_data = '0;

  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      ready = 1'b0;
    end else begin
      if (stall_left > 0 && valid && rcv_cnt == stall_at) begin
        ready = 1'b0;
        if (!stall_seen) begin
          stall_seen = 1;
          stall_data = data;
        end
        chk("stall_data", data, stall_data);
        chk("stall_no_bus", bus_en, 0);
        stall_left--;
      end else begin
        ready = rand_ready ? ($urandom_range(1, 0) == 1) : 1'b1;
      end
      if (valid && ready) begin
        chk("stream_avail", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) chk("stream_byte", data, exp_q.pop_front());
        rcv_cnt++;
      end
    end
  end

  // ---------------- protocol monitor (just after each edge) ----------------
  int   done_cnt = 0, err_cnt = 0, en_cyc = 0, en_run = 0, last_run = 0, last_done_cyc = 0;
  logic prev_en = 0, prev_valid = 0;
  logic [12:0] prev_bus = '0;
  logic [7:0]  prev_data = '0;

  initial forever begin
    @(posedge clk);
    #1;
    if (!rst_n) begin
      prev_en = 0;
      prev_valid = 0;
      en_run = 0;
    end else begin
      if (done) begin
        done_cnt++;
        last_done_cyc = cyc;
      end
      if (err) begin
        err_cnt++;
        chk("err_with_done", done, 1);
      end
      if (prev_en && bus_ack) chk("en_gap", bus_en, 0);
      if (prev_en && !bus_ack && bus_en) chk("bus_hold", {bus_wr, bus_addr, bus_wdata}, prev_bus);
      if (prev_valid && !ready) begin
        chk("valid_hold", valid, 1);
        chk("data_hold", data, prev_data);
      end
      if (valid) chk("no_bus_in_out", bus_en, 0);
      if (bus_en) begin
        en_cyc++;
        en_run++;
      end else if (en_run > 0) begin
        last_run = en_run;
        en_run = 0;
      end
      prev_en = bus_en;
      prev_bus = {bus_wr, bus_addr, bus_wdata};
      prev_valid = valid;
      prev_data = data;
    end
  end

  // ---------------- driver tasks ----------------
  int done_base = 0, err_base = 0, en_base = 0, start_cyc = 0;

  task automatic start_xfer(input logic [23:0] a, input int l);
    @(negedge clk);
    chk("idle_before_start", busy, 0);
    txdr_q.delete();
    csr_q.delete();
    exp_q.delete();
    rx_cnt = 0; sr_reads = 0; acc_idx = 0; sr_at_tx0 = -1; rcv_cnt = 0;
    done_base = done_cnt; err_base = err_cnt; en_base = en_cyc;
    for (int k = 0; k < l; k++)
      exp_q.push_back(force_on ? force_q[k] : mem_byte(a + 24'(k)));
    addr = a;
    len = LEN_W'(l);
    start = 1'b1;
    start_cyc = cyc;
    @(negedge clk);
    start = 1'b0;
    addr = 24'($urandom);
    len = LEN_W'($urandom);
    chk("busy_rise", busy, 1);
  endtask

  task automatic wait_done(input int budget);
    bit seen;
    seen = 0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1;
    end
    chk("done_seen", seen, 1);
  endtask

  task automatic check_xfer(input logic [23:0] a, input int l);
    logic [7:0] exp_tx[$];
    repeat (2) @(negedge clk);
    chk("done_pulses", done_cnt - done_base, 1);
    chk("err_pulses", err_cnt - err_base, 0);
    chk("busy_after", busy, 0);
    chk("stream_len", rcv_cnt, l);
    chk("exp_empty", exp_q.size(), 0);
    if (l == 0) begin
      chk("len0_no_bus", en_cyc - en_base, 0);
      chk("len0_no_csr", csr_q.size(), 0);
    end else begin
      exp_tx = '{8'h03, a[23:16], a[15:8], a[7:0]};
      for (int k = 0; k < l; k++) exp_tx.push_back(8'h00);
      chk("txdr_count", txdr_q.size(), exp_tx.size());
      for (int k = 0; k < exp_tx.size() && k < txdr_q.size(); k++)
        chk("txdr_byte", txdr_q[k], exp_tx[k]);
      chk("csr_count", csr_q.size(), 2);
      if (csr_q.size() == 2) begin
        chk("csr_on", csr_q[0], 8'hFE);
        chk("csr_off", csr_q[1], 8'hFF);
      end
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [23:0] ra;
    int rl;

    // reset state
    #12;
    chk("reset_outputs", {busy, done, err, valid, bus_en}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("post_reset_outputs", {busy, done, err, valid, bus_en, data}, 0);

    // 1: known read with fixed data
    force_on = 1;
    force_q = '{8'hA5, 8'h5A, 8'hC3};
    start_xfer(24'h100000, 3);
    wait_done(5000);
    check_xfer(24'h100000, 3);
    force_on = 0;

    // 2: zero-length transfer
    start_xfer(24'h123456, 0);
    wait_done(50);
    chk("len0_latency", last_done_cyc - start_cyc, 2);
    check_xfer(24'h123456, 0);

    // 3: transmitter not ready for 10 status reads
    trdy_block = 10;
    start_xfer(24'h00ABCD, 2);
    wait_done(5000);
    chk("sr_reads_before_tx", sr_at_tx0, 11);
    check_xfer(24'h00ABCD, 2);

    // 4: consumer stalls 50 cycles on the second of four bytes
    stall_at = 1; stall_left = 50; stall_seen = 0;
    start_xfer(24'h3C3C00, 4);
    wait_done(5000);
    chk("stall_consumed", stall_left, 0);
    check_xfer(24'h3C3C00, 4);
    stall_at = -1;

    // 5: second access never acknowledged
    withhold_at = 2;
    start_xfer(24'h000010, 2);
    wait_done(2000);
    repeat (2) @(negedge clk);
    chk("tmo_en_cycles", last_run, 255);
    chk("tmo_done_pulses", done_cnt - done_base, 1);
    chk("tmo_err_pulses", err_cnt - err_base, 1);
    chk("tmo_no_cs_off", csr_q.size(), 1);
    chk("tmo_bus_idle", bus_en, 0);
    withhold_at = 0;
    start_xfer(24'h000010, 2);
    wait_done(5000);
    check_xfer(24'h000010, 2);

    // random transfers with ack delays, status polling and consumer backpressure
    ack_dly_max = 3; rand_sr = 1; rand_ready = 1;
    for (int i = 0; i < 6; i++) begin
      ra = (i == 1) ? 24'hFFFFFE : 24'($urandom);
      rl = $urandom_range(10, 1);
      start_xfer(ra, rl);
      if (i == 2) begin
        repeat (20) @(negedge clk);
        chk("busy_mid_xfer", busy, 1);
        start = 1'b1;
        addr = 24'($urandom);
        len = LEN_W'($urandom_range(20, 1));
        @(negedge clk);
        start = 1'b0;
      end
      wait_done(8000);
      if (i == 4) begin
        start = 1'b1;
        addr = 24'h000001;
        len = LEN_W'(1);
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("start_on_done_ignored", busy, 0);
      end
      check_xfer(ra, rl);
    end

    // 6: asynchronous reset in the middle of a transfer
    start_xfer(24'h0F0F0F, 8);
    repeat (40) @(negedge clk);
    chk("busy_before_rst", busy, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_async", {busy, done, err, valid, bus_en, bus_wr, bus_addr, bus_wdata, data}, 0);
    exp_q.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    start_xfer(24'h0F0F0F, 1);
    wait_done(5000);
    check_xfer(24'h0F0F0F, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
